// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle logic/shift/compare/rotate ops, WIDTH-step iterative MUL and (with ALU_ITER_DIV_EN) DIVU/REMU.
// Latency 1 cycle (single) or WIDTH+1 (iterative); ready_o drops while iterating and while a result waits on ready_i.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SRA   = 4'd3;
    localparam logic [3:0] OP_SRL   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_ROL   = 4'd10;
    localparam logic [3:0] OP_MULLO = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_accept;
    logic [SHW-1:0]   r_count;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_illegal;

    logic [SHW-1:0]     w_sh;
    logic [2*WIDTH-1:0] w_rot;
    logic [WIDTH-1:0]   w_res;
    logic               w_ill;
    logic               w_iter;
    logic               w_is_div;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_hi_nx;
    logic [WIDTH-1:0]   w_lo_nx;
    logic [WIDTH-1:0]   w_iter_res;

    assign w_sh      = b_i[SHW-1:0];
    assign result_o  = r_result;
    assign illegal_o = r_illegal;

    always_ff @(posedge clk) begin
        if (!n_reset) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        case (r_state)
            IDLE: ready_o = 1'b1;
            BUSY: if (r_count == LAST) w_state_nx = DONE;
            DONE: begin
                valid_o = 1'b1;
                ready_o = ready_i;
                if (ready_i) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
        w_accept = valid_i && ready_o;
        if (w_accept) w_state_nx = w_iter ? BUSY : DONE;
    end

    // Single-cycle result; rotate takes the upper half of a doubled operand shifted left.
    always_comb begin
        w_rot    = {a_i, a_i} << w_sh;
        w_res    = '0;
        w_ill    = 1'b0;
        w_iter   = 1'b0;
        w_is_div = 1'b0;
        case (op_i)
            OP_ADD:  w_res = a_i + b_i;
            OP_SUB:  w_res = a_i - b_i;
            OP_SLL:  w_res = a_i << w_sh;
            OP_SRA:  w_res = $signed(a_i) >>> w_sh;
            OP_SRL:  w_res = a_i >> w_sh;
            OP_AND:  w_res = a_i & b_i;
            OP_OR:   w_res = a_i | b_i;
            OP_NOR:  w_res = ~(a_i | b_i);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
            OP_ROL:  w_res = w_rot[2*WIDTH-1:WIDTH];
            OP_MULLO, OP_MULHU: w_iter = 1'b1;
`ifdef ALU_ITER_DIV_EN
            OP_DIVU: begin
                w_is_div = 1'b1;
                if (b_i == '0) w_res  = '1;
                else           w_iter = 1'b1;
            end
            OP_REMU: begin
                w_is_div = 1'b1;
                if (b_i == '0) w_res  = a_i;
                else           w_iter = 1'b1;
            end
`endif
            default: w_ill = 1'b1;
        endcase
    end

`ifdef ALU_ITER_DIV_EN
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_a;
    assign w_ge     = w_rem_sh >= {1'b0, r_a};
`endif

    // Mul: r_hi:r_lo shifts right with r_a added on multiplier LSB. Div: r_lo dividend/quotient, r_hi remainder.
    always_comb begin
        w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_a : '0)};
        w_hi_nx = w_sum[WIDTH:1];
        w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_ITER_DIV_EN
        if (r_op == OP_DIVU || r_op == OP_REMU) begin
            w_hi_nx = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            w_lo_nx = {r_lo[WIDTH-2:0], w_ge};
        end
`endif
        case (r_op)
            OP_MULHU: w_iter_res = w_hi_nx;
            OP_REMU:  w_iter_res = w_hi_nx;
            default:  w_iter_res = w_lo_nx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_count   <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            if (w_iter) begin
                r_op    <= op_i;
                r_count <= '0;
                r_hi    <= '0;
                r_a     <= w_is_div ? b_i : a_i;
                r_lo    <= w_is_div ? a_i : b_i;
            end else begin
                r_result  <= w_res;
                r_illegal <= w_ill;
            end
        end else if (r_state == BUSY) begin
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_count <= r_count + SHW'(1);
            if (r_count == LAST) begin
                r_result  <= w_iter_res;
                r_illegal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (WIDTH=32); expected responses come from a behavioural model via a scoreboard queue.
module tb_alu_iter;
    localparam int W = 32;
`ifdef ALU_ITER_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         n_reset;
    logic         valid_i;
    logic         ready_o;
    logic [3:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;
    logic         illegal_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W:0] sb_q[$];

    alu_iter #(.WIDTH(W)) dut (
        .clk(clk), .n_reset(n_reset), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [4:0]     sh;
        logic [W-1:0]   r;
        logic           ill;
        p   = {32'd0, a} * {32'd0, b};
        sh  = b[4:0];
        r   = '0;
        ill = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a << sh;
            4'd3:  r = W'($signed(a) >>> sh);
            4'd4:  r = a >> sh;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = ~(a | b);
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = (a << sh) | (a >> (32 - int'(sh)));
            4'd11: r = p[31:0];
            4'd12: r = p[63:32];
            4'd13: if (DIV_EN) r = (b == 0) ? 32'hFFFF_FFFF : a / b; else ill = 1'b1;
            4'd14: if (DIV_EN) r = (b == 0) ? a : a % b;            else ill = 1'b1;
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    function automatic bit is_iter(input logic [3:0] op, input logic [W-1:0] b);
        return (op == 4'd11) || (op == 4'd12) || (DIV_EN && (op == 4'd13 || op == 4'd14) && b != 0);
    endfunction

    task automatic consume(input string tag);
        logic [W:0] e;
        check({tag, "_valid"}, 64'(valid_o), 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_result"}, 64'(result_o), 64'(e[W-1:0]));
            check({tag, "_illegal"}, 64'(illegal_o), 64'(e[W]));
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        int lat;
        int busy;
        @(negedge clk);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b; ready_i = 1'b1;
        k = 0;
        while (!ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_accept"}, 64'(ready_o), 64'd1);
        sb_q.push_back(model(op, a, b));
        @(negedge clk);
        valid_i = 1'b0; op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
        lat = 1;
        busy = 0;
        while (!valid_o && lat < 100) begin
            if (!ready_o) busy++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), is_iter(op, b) ? 64'(W + 1) : 64'd1);
        check({tag, "_busy"}, 64'(busy), is_iter(op, b) ? 64'(W) : 64'd0);
        consume(tag);
    endtask

    initial begin
        logic [W:0] e;
        int vcnt;
        n_reset = 1'b0; valid_i = 1'b0; ready_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_illegal", 64'(illegal_o), 64'd0);
        n_reset = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);

        do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
        do_op("rol", 4'd10, 32'h8000_0001, 32'd4);
        do_op("rol0", 4'd10, 32'h1234_5678, 32'd32);
        do_op("sub", 4'd1, 32'd5, 32'd7);
        do_op("sll", 4'd2, 32'h0000_0003, 32'h0000_0021);
        do_op("sra", 4'd3, 32'h8000_0000, 32'd4);
        do_op("srl", 4'd4, 32'h8000_0000, 32'd31);
        do_op("and", 4'd5, 32'hF0F0_1234, 32'h0FF0_FF00);
        do_op("or", 4'd6, 32'hF0F0_0000, 32'h0000_1234);
        do_op("nor", 4'd7, 32'hF0F0_0000, 32'h0000_1234);
        do_op("mulhu", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mullo", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mul_mix", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
        do_op("divu", 4'd13, 32'd100, 32'd7);
        do_op("remu", 4'd14, 32'd100, 32'd7);
        do_op("divu_big", 4'd13, 32'hFFFF_FFFF, 32'd3);
        do_op("divu_z", 4'd13, 32'd100, 32'd0);
        do_op("remu_z", 4'd14, 32'd5, 32'd0);
        do_op("rsvd", 4'd15, 32'd9, 32'd9);

        // Back-to-back SLT then SLTU, then a three-cycle consumer stall.
        @(negedge clk);
        ready_i = 1'b1; valid_i = 1'b1; op_i = 4'd8; a_i = 32'hFFFF_FFFF; b_i = 32'd1;
        check("b2b_ready0", 64'(ready_o), 64'd1);
        sb_q.push_back(model(4'd8, 32'hFFFF_FFFF, 32'd1));
        @(negedge clk);
        check("b2b_ready1", 64'(ready_o), 64'd1);
        consume("b2b_slt");
        op_i = 4'd9;
        e = model(4'd9, 32'hFFFF_FFFF, 32'd1);
        sb_q.push_back(e);
        @(negedge clk);
        consume("b2b_sltu");
        ready_i = 1'b0; valid_i = 1'b0; a_i = 32'd0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 64'(valid_o), 64'd1);
            check("stall_result", 64'(result_o), 64'(e[W-1:0]));
            check("stall_ready", 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        check("stall_drain", 64'(valid_o), 64'd0);

        // Reset during a long operation discards it.
        valid_i = 1'b1; op_i = DIV_EN ? 4'd13 : 4'd11; a_i = 32'd1000; b_i = 32'd3;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (8) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) vcnt++;
        end
        check("abort_no_valid", 64'(vcnt), 64'd0);
        check("abort_ready", 64'(ready_o), 64'd1);
        do_op("post_rst_add", 4'd0, 32'd2, 32'd3);

        for (int i = 0; i < 12; i++) begin
            do_op("rand", 4'($urandom_range(0, 15)), $urandom, (i == 5) ? 32'd0 : $urandom);
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshaked successor to the core's single-cycle ALU. Executes the existing logical, shift, compare and rotate operations in one cycle. Adds iterative unsigned multiply and divide/remainder, which take multiple cycles. Sits in the execute stage behind a valid/ready interface so the pipeline can stall on long operations.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  in  1  core clock, all state on rising edge
- n_reset  in  1  reset, synchronous, active-low
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request this cycle
- op_i  in  4  operation code (below)
- a_i  in  WIDTH  operand A (rd)
- b_i  in  WIDTH  operand B (rs)
- valid_o  out  1  result valid
- ready_i  in  1  consumer takes result this cycle
- result_o  out  WIDTH  result
- illegal_o  out  1  op was reserved/disabled; qualified by valid_o

## Operation
- Opcodes:
  - 0 ADD a+b, 1 SUB a−b, 2 SLL a<<b[SHW-1:0], 3 SRA signed a>>>b[SHW-1:0], 4 SRL a>>b[SHW-1:0]
  - 5 AND, 6 OR, 7 NOR, 8 SLT signed a<b→1 else 0, 9 SLTU unsigned, 10 ROL rotate a left by b[SHW-1:0]
  - 11 MULLO low WIDTH of a×b, 12 MULHU high WIDTH of unsigned a×b, 13 DIVU a/b, 14 REMU a%b, 15 reserved
- All arithmetic is modulo 2^WIDTH; no overflow flag.
- Reserved op: result 0, illegal_o=1, single-cycle path.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept on valid_i&&ready_o. Single-cycle ops (0–10, 15) load the result register and go to DONE. Ops 11–14 latch operands, clear the count, and go to BUSY.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle. After step WIDTH, the result is written and the FSM goes to DONE.
  - DONE: valid_o=1. On ready_i, go to IDLE, or accept a new request in the same cycle (back-to-back).
- ready_o = (state==IDLE) || (state==DONE && ready_i). It is 0 in BUSY.
- Divide by zero (b=0): DIVU → all ones, REMU → a. No iteration; result goes to DONE in one cycle with illegal_o=0.
- result_o/illegal_o hold stable while valid_o=1 && ready_i=0.
- Operands and op are sampled only at acceptance. Input changes afterwards are ignored.

## Timing
- Reset (n_reset=0 at an edge): state=IDLE, valid_o=0, result_o=0, illegal_o=0, count=0. ready_o=1 from the first cycle after reset.
- Reset mid-BUSY or in DONE aborts the operation. The result is discarded and never presented.
- Single-cycle op accepted at edge N: valid_o=1 after edge N+1's setup, i.e. visible in cycle N+1.
- MUL/DIV accepted at edge N: BUSY for cycles N+1 … N+WIDTH. valid_o=1 in cycle N+WIDTH+1. Latency is WIDTH+1 cycles.
- Throughput: one single-cycle op per cycle when ready_i stays 1.
- valid_i while ready_o=0 is not accepted. The requester must hold valid_i and inputs until acceptance.

## Configuration
- ALU_ITER_DIV_EN defined: DIVU/REMU are implemented as above.
- ALU_ITER_DIV_EN undefined: no divider hardware. Ops 13/14 behave as reserved (single cycle, result 0, illegal_o=1). MULLO/MULHU are unaffected.

## Test plan
- Reset then ADD a=0xFFFFFFFF b=1 (WIDTH=32) → valid_o next cycle, result 0, illegal_o 0. ROL a=0x80000001 b=4 → 0x00000018.
- MULHU a=0xFFFFFFFF b=0xFFFFFFFF → ready_o low 32 cycles, valid_o in cycle 33, result 0xFFFFFFFE. MULLO of the same operands → 0x00000001.
- DIVU a=100 b=7 → 14 after 33 cycles. REMU gives 2. DIVU b=0 → 0xFFFFFFFF in 1 cycle. REMU b=0 a=5 → 5.
- Back-to-back SLT (−1 < 1 → 1) then SLTU (0xFFFFFFFF < 1 → 0) with ready_i=1 → valid_o on consecutive cycles, ready_o constantly 1. Hold ready_i=0 for 3 cycles → result_o stable, ready_o 0.
- Op 15 → result 0, illegal_o 1, 1 cycle. Without ALU_ITER_DIV_EN, op 13 gives the same response.
- Assert n_reset=0 at cycle 10 of a DIVU → valid_o stays 0. The next ADD 2+3 returns 5 normally.
